// File: rtl/act_unit.sv
// Multi-mode activation stage (bypass / ReLU / leaky ReLU / clipped ReLU) over CH_NUM signed
// lanes, with a two-stage valid/ready pipeline. Config writes are taken only while drained.
module act_unit #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH  = 4,
    parameter int unsigned CH_NUM      = 16,
    parameter int unsigned SHIFT_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din_vld,
    output logic                         din_rdy,
    input  logic [CH_NUM*DATA_WIDTH-1:0] din,
    output logic                         dout_vld,
    input  logic                         dout_rdy,
    output logic [CH_NUM*DATA_WIDTH-1:0] dout,
    input  logic                         cfg_wr,
    input  logic [1:0]                   cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic [DATA_WIDTH-1:0]        cfg_clip,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int unsigned BUS_WIDTH = CH_NUM * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] CLIP_RST = DATA_WIDTH'(64'd6 << FRAC_WIDTH);

    // The reset clip value 6.0 must be representable as a positive lane value.
    if ((64'd6 << FRAC_WIDTH) > ((64'd1 << (DATA_WIDTH - 1)) - 64'd1)) begin : g_frac_check
        $error("act_unit: 6.0 does not fit in the configured fixed-point format");
    end

    typedef enum logic [1:0] {
        ModeBypass = 2'd0,
        ModeRelu   = 2'd1,
        ModeLeaky  = 2'd2,
        ModeClip   = 2'd3
    } mode_e;

    mode_e                          mode_q;
    logic [SHIFT_WIDTH-1:0]         shift_q;
    logic signed [DATA_WIDTH-1:0]   clip_q;
    logic signed [DATA_WIDTH-1:0]   clip_ceil;

    logic                 s1_vld_q;
    logic                 dout_vld_q;
    logic                 cfg_err_q;
    logic [BUS_WIDTH-1:0] s1_d;
    logic [BUS_WIDTH-1:0] s1_q;
    logic [BUS_WIDTH-1:0] s2_d;
    logic [BUS_WIDTH-1:0] dout_q;

    logic en1;
    logic en2;
    logic accept;
    logic cfg_load;

    assign en2      = !dout_vld_q || dout_rdy;
    assign en1      = !s1_vld_q || en2;
    assign din_rdy  = en1 && !cfg_wr;
    assign accept   = din_vld && din_rdy;
    assign busy     = s1_vld_q || dout_vld_q;
    assign cfg_load = cfg_wr && !busy;

    assign dout_vld = dout_vld_q;
    assign dout     = dout_q;
    assign cfg_err  = cfg_err_q;

    // Stage 1 only ever passes non-negative values in clip mode, so a negative ceiling
    // collapses to zero.
    assign clip_ceil = clip_q[DATA_WIDTH-1] ? '0 : clip_q;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] x;
        logic signed [DATA_WIDTH-1:0] leak;
        logic signed [DATA_WIDTH-1:0] y1;
        logic signed [DATA_WIDTH-1:0] s1;
        logic signed [DATA_WIDTH-1:0] y2;

        assign x    = din[i*DATA_WIDTH +: DATA_WIDTH];
        assign leak = x >>> shift_q;
        assign s1   = s1_q[i*DATA_WIDTH +: DATA_WIDTH];

        always_comb begin
            y1 = x;
            unique case (mode_q)
                ModeBypass:         y1 = x;
                ModeRelu, ModeClip: y1 = x[DATA_WIDTH-1] ? '0 : x;
                ModeLeaky:          y1 = x[DATA_WIDTH-1] ? leak : x;
            endcase
        end

        assign y2 = ((mode_q == ModeClip) && (s1 > clip_ceil)) ? clip_ceil : s1;

        assign s1_d[i*DATA_WIDTH +: DATA_WIDTH] = y1;
        assign s2_d[i*DATA_WIDTH +: DATA_WIDTH] = y2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= ModeRelu;
            shift_q    <= SHIFT_WIDTH'(3);
            clip_q     <= CLIP_RST;
            cfg_err_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_q       <= '0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            cfg_err_q <= cfg_wr && busy;
            if (cfg_load) begin
                mode_q  <= mode_e'(cfg_mode);
                shift_q <= cfg_shift;
                clip_q  <= cfg_clip;
            end
            if (en1) begin
                s1_vld_q <= accept;
                if (accept) begin
                    s1_q <= s1_d;
                end
            end
            if (en2) begin
                dout_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    dout_q <= s2_d;
                end
            end
        end
    end

endmodule
